// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU datapath: next-PC source select,
// branch condition codes and instruction field positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQ   = 2'b01,
        BR_NE   = 2'b10,
        BR_RSVD = 2'b11
    } branch_e;

    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 26;
    localparam int JUMP_FIELD_W = 26;

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch condition: BEQ taken on Zero, BNE taken on !Zero,
// the reserved code never taken.
module branch_resolve
    import cpu_pkg::*;
(
    input  logic [1:0] branch_i,
    input  logic       zero_i,
    output logic       cond_o
);

    always_comb begin
        cond_o = 1'b0;
        case (branch_e'(branch_i))
            BR_EQ:   cond_o = zero_i;
            BR_NE:   cond_o = ~zero_i;
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC / IR / ALUOut stage of the multi-cycle CPU: resolves branches and jumps,
// returns the opcode to the control FSM and keeps fetch/taken debug counters.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TAKEN_W  = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               PCWrite,
    input  logic [1:0]         PCSrc,
    input  logic [1:0]         Branch,
    input  logic               IRWrite,
    input  logic               Zero,
    input  logic [ADDR_W-1:0]  ALUResult,
    input  logic [INSTR_W-1:0] MemData,
    output logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] Instr,
    output logic [5:0]         Opcode,
    output logic [ADDR_W-1:0]  ALUOut,
    output logic               BranchTaken,
    output logic [31:0]        InstrCount,
    output logic [TAKEN_W-1:0] TakenCount
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  alu_out_q;
    logic               branch_taken_q;
    logic [31:0]        instr_count_q, instr_count_d;
    logic [TAKEN_W-1:0] taken_count_q, taken_count_d;
    logic               cond;
    logic               pc_en;
    logic [ADDR_W-1:0]  jump_target;

    branch_resolve u_branch_resolve (
        .branch_i (Branch),
        .zero_i   (Zero),
        .cond_o   (cond)
    );

    assign pc_en = PCWrite | cond;
    // PC has already been incremented at fetch, so its upper bits are the delay-slot region.
    assign jump_target = {pc_q[ADDR_W-1:JUMP_FIELD_W], instr_q[JUMP_FIELD_W-1:0]};

    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_count_d = instr_count_q;
        taken_count_d = taken_count_q;
        if (pc_en) begin
            case (pcsrc_e'(PCSrc))
                PCSRC_ALU:    pc_d = ALUResult;
                PCSRC_ALUOUT: pc_d = alu_out_q;
                PCSRC_JUMP:   pc_d = jump_target;
                default:      pc_d = pc_q;
            endcase
        end
        if (IRWrite) begin
            instr_d = MemData;
        end
        if (IRWrite && PCWrite) begin
            instr_count_d = instr_count_q + 32'd1;
        end
        if (cond) begin
            taken_count_d = taken_count_q + TAKEN_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q           <= RESET_PC;
            instr_q        <= '0;
            alu_out_q      <= '0;
            branch_taken_q <= 1'b0;
            instr_count_q  <= '0;
            taken_count_q  <= '0;
        end else begin
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            alu_out_q      <= ALUResult;
            branch_taken_q <= cond;
            instr_count_q  <= instr_count_d;
            taken_count_q  <= taken_count_d;
        end
    end

    assign PC          = pc_q;
    assign Instr       = instr_q;
    assign Opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign ALUOut      = alu_out_q;
    assign BranchTaken = branch_taken_q;
    assign InstrCount  = instr_count_q;
    assign TakenCount  = taken_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, random stimulus against a
// behavioural model, and a taken-counter wrap sequence.
module tb_pc_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic        PCWrite;
    logic [1:0]  PCSrc;
    logic [1:0]  Branch;
    logic        IRWrite;
    logic        Zero;
    logic [31:0] ALUResult;
    logic [31:0] MemData;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic [5:0]  Opcode;
    logic [31:0] ALUOut;
    logic        BranchTaken;
    logic [31:0] InstrCount;
    logic [15:0] TakenCount;

    pc_fetch_unit dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .PCWrite     (PCWrite),
        .PCSrc       (PCSrc),
        .Branch      (Branch),
        .IRWrite     (IRWrite),
        .Zero        (Zero),
        .ALUResult   (ALUResult),
        .MemData     (MemData),
        .PC          (PC),
        .Instr       (Instr),
        .Opcode      (Opcode),
        .ALUOut      (ALUOut),
        .BranchTaken (BranchTaken),
        .InstrCount  (InstrCount),
        .TakenCount  (TakenCount)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic        rst;
        logic        pcw;
        logic [1:0]  pcsrc;
        logic [1:0]  br;
        logic        irw;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_aluout;
        logic        e_bt;
        logic [31:0] e_ic;
        logic [15:0] e_tc;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    int n_vec = 0;
    int n_err = 0;

    // Behavioural reference state
    logic [31:0] m_pc, m_instr, m_aluout, m_ic;
    logic        m_bt;
    logic [15:0] m_tc;

    function automatic vec_t mk(input logic rst, input logic pcw, input logic [1:0] pcsrc,
                                input logic [1:0] br, input logic irw, input logic zero,
                                input logic [31:0] alu, input logic [31:0] mem,
                                input logic [31:0] e_pc, input logic [31:0] e_instr,
                                input logic [31:0] e_aluout, input logic e_bt,
                                input logic [31:0] e_ic, input logic [15:0] e_tc);
        vec_t v;
        v.rst = rst; v.pcw = pcw; v.pcsrc = pcsrc; v.br = br; v.irw = irw; v.zero = zero;
        v.alu = alu; v.mem = mem; v.e_pc = e_pc; v.e_instr = e_instr; v.e_aluout = e_aluout;
        v.e_bt = e_bt; v.e_ic = e_ic; v.e_tc = e_tc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One rising edge as seen by the specification's rules, from pre-edge values.
    task automatic model_step;
        bit          taken;
        logic [31:0] npc;
        if (Reset) begin
            m_pc = 32'd0; m_instr = 32'd0; m_aluout = 32'd0;
            m_bt = 1'b0; m_ic = 32'd0; m_tc = 16'd0;
        end else begin
            taken = (Branch == 2'd1 && Zero) || (Branch == 2'd2 && !Zero);
            npc = m_pc;
            if (PCWrite || taken) begin
                case (PCSrc)
                    2'd0:    npc = ALUResult;
                    2'd1:    npc = m_aluout;
                    2'd2:    npc = (m_pc & 32'hFC00_0000) | (m_instr & 32'h03FF_FFFF);
                    default: npc = m_pc;
                endcase
            end
            if (IRWrite) m_instr = MemData;
            if (IRWrite && PCWrite) m_ic = m_ic + 32'd1;
            if (taken) m_tc = 16'((int'(m_tc) + 1) % 65536);
            m_bt = taken;
            m_aluout = ALUResult;
            m_pc = npc;
        end
    endtask

    task automatic drive(input logic rst, input logic pcw, input logic [1:0] pcsrc,
                         input logic [1:0] br, input logic irw, input logic zero,
                         input logic [31:0] alu, input logic [31:0] mem);
        Reset = rst; PCWrite = pcw; PCSrc = pcsrc; Branch = br;
        IRWrite = irw; Zero = zero; ALUResult = alu; MemData = mem;
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".PC"},          PC,                  m_pc);
        chk({tag, ".Instr"},       Instr,               m_instr);
        chk({tag, ".Opcode"},      {26'd0, Opcode},     {26'd0, m_instr[31:26]});
        chk({tag, ".ALUOut"},      ALUOut,              m_aluout);
        chk({tag, ".BranchTaken"}, {31'd0, BranchTaken}, {31'd0, m_bt});
        chk({tag, ".InstrCount"},  InstrCount,          m_ic);
        chk({tag, ".TakenCount"},  {16'd0, TakenCount}, {16'd0, m_tc});
    endtask

    initial begin
        Reset = 1'b1; PCWrite = 1'b0; PCSrc = 2'd0; Branch = 2'd0;
        IRWrite = 1'b0; Zero = 1'b0; ALUResult = 32'd0; MemData = 32'd0;
        m_pc = 32'd0; m_instr = 32'd0; m_aluout = 32'd0; m_bt = 1'b0; m_ic = 32'd0; m_tc = 16'd0;

        //            rst  pcw pcsrc br  irw z  alu            mem            e_pc           e_instr        e_aluout       bt  ic  tc
        vecs[0]  = mk(1, 0, 2'd0, 2'd0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         0, 0, 0);
        vecs[1]  = mk(0, 1, 2'd0, 2'd0, 1, 0, 32'h1,         32'h0C000005,  32'h1,         32'h0C000005,  32'h1,         0, 1, 0);
        vecs[2]  = mk(0, 0, 2'd0, 2'd0, 0, 0, 32'h40,        32'h0,         32'h1,         32'h0C000005,  32'h40,        0, 1, 0);
        vecs[3]  = mk(0, 0, 2'd1, 2'd1, 0, 1, 32'h99,        32'h0,         32'h40,        32'h0C000005,  32'h99,        1, 1, 1);
        vecs[4]  = mk(0, 0, 2'd0, 2'd0, 0, 0, 32'h50,        32'h0,         32'h40,        32'h0C000005,  32'h50,        0, 1, 1);
        vecs[5]  = mk(0, 0, 2'd1, 2'd2, 0, 1, 32'h80,        32'h0,         32'h40,        32'h0C000005,  32'h80,        0, 1, 1);
        vecs[6]  = mk(0, 0, 2'd1, 2'd3, 0, 1, 32'h0,         32'h0,         32'h40,        32'h0C000005,  32'h0,         0, 1, 1);
        vecs[7]  = mk(0, 1, 2'd3, 2'd0, 0, 0, 32'h7,         32'h0,         32'h40,        32'h0C000005,  32'h7,         0, 1, 1);
        vecs[8]  = mk(0, 0, 2'd0, 2'd0, 1, 0, 32'h0,         32'h0800ABCD,  32'h40,        32'h0800ABCD,  32'h0,         0, 1, 1);
        vecs[9]  = mk(0, 1, 2'd0, 2'd0, 0, 0, 32'h10000004,  32'h0,         32'h10000004,  32'h0800ABCD,  32'h10000004,  0, 1, 1);
        vecs[10] = mk(0, 1, 2'd2, 2'd0, 0, 0, 32'h0,         32'h0,         32'h1000ABCD,  32'h0800ABCD,  32'h0,         0, 1, 1);
        vecs[11] = mk(0, 1, 2'd0, 2'd1, 1, 1, 32'h200,       32'h12345678,  32'h200,       32'h12345678,  32'h200,       1, 2, 2);
        vecs[12] = mk(0, 0, 2'd0, 2'd2, 0, 0, 32'h300,       32'h0,         32'h300,       32'h12345678,  32'h300,       1, 2, 3);
        vecs[13] = mk(1, 1, 2'd1, 2'd1, 1, 1, 32'h55,        32'hFFFFFFFF,  32'h0,         32'h0,         32'h0,         0, 0, 0);

        @(posedge Clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].rst, vecs[i].pcw, vecs[i].pcsrc, vecs[i].br,
                  vecs[i].irw, vecs[i].zero, vecs[i].alu, vecs[i].mem);
            chk({tag, ".PC"},          PC,                    vecs[i].e_pc);
            chk({tag, ".Instr"},       Instr,                 vecs[i].e_instr);
            chk({tag, ".Opcode"},      {26'd0, Opcode},       {26'd0, vecs[i].e_instr[31:26]});
            chk({tag, ".ALUOut"},      ALUOut,                vecs[i].e_aluout);
            chk({tag, ".BranchTaken"}, {31'd0, BranchTaken},  {31'd0, vecs[i].e_bt});
            chk({tag, ".InstrCount"},  InstrCount,            vecs[i].e_ic);
            chk({tag, ".TakenCount"},  {16'd0, TakenCount},   {16'd0, vecs[i].e_tc});
            $display("%s: PC=%h Instr=%h Op=%h ALUOut=%h BT=%0d IC=%0d TC=%0d",
                     tag, PC, Instr, Opcode, ALUOut, BranchTaken, InstrCount, TakenCount);
        end

        // Random traffic against the behavioural model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(63) == 0), 1'($urandom), 2'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom), $urandom, $urandom);
            chk_model($sformatf("rnd%0d", i));
        end
        $display("random: 3000 cycles, PC=%h IC=%0d TC=%0d", PC, InstrCount, TakenCount);

        // Taken-branch counter wrap: 65535 taken BEQs, then one more
        drive(1, 0, 2'd0, 2'd0, 0, 0, 32'h0, 32'h0);
        chk_model("wrap.reset");
        for (int i = 0; i < 65535; i++) begin
            drive(0, 0, 2'd1, 2'd1, 0, 1, $urandom, 32'h0);
        end
        chk_model("wrap.ffff");
        chk("wrap.ffff.TakenCount", {16'd0, TakenCount}, 32'h0000FFFF);
        $display("wrap: TC=%h before final branch", TakenCount);
        drive(0, 0, 2'd1, 2'd1, 0, 1, 32'h1234, 32'h0);
        chk_model("wrap.zero");
        chk("wrap.zero.TakenCount", {16'd0, TakenCount}, 32'h0);
        $display("wrap: TC=%h BT=%0d after final branch", TakenCount, BranchTaken);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and instruction-register stage of the multi-cycle 32-bit CPU; sits directly downstream of the Moore control FSM and upstream of it via Opcode.
Consumes PCWrite, PCSrc, Branch and IRWrite from the FSM and Zero from the ALU. Holds PC, IR and the ALU-output register, and resolves conditional branches and jumps.
Drives Opcode back to the FSM, plus debug counters.

Parameters:
ADDR_W, 32, PC / ALU result width
INSTR_W, 32, instruction width; opcode is Instr[31:26]
RESET_PC, 0, PC value after reset
TAKEN_W, 16, width of taken-branch counter

Ports:
Clk  input  1  system clock, all state updates on posedge
Reset  input  1  synchronous, active-high reset
PCWrite  input  1  unconditional PC update enable
PCSrc  input  2  next-PC source: 00 ALUResult, 01 ALUOut (branch target), 10 jump target, 11 reserved
Branch  input  2  branch condition: 00 none, 01 BEQ (taken if Zero), 10 BNE (taken if !Zero), 11 reserved
IRWrite  input  1  latch MemData into IR
Zero  input  1  ALU zero flag, same cycle
ALUResult  input  ADDR_W  combinational ALU output
MemData  input  INSTR_W  instruction memory read data at address PC
PC  output  ADDR_W  current program counter (registered)
Instr  output  INSTR_W  instruction register contents
Opcode  output  6  Instr[31:26], feeds control FSM
ALUOut  output  ADDR_W  ALUResult registered every cycle
BranchTaken  output  1  registered one-cycle pulse after a taken branch
InstrCount  output  32  fetched-instruction counter
TakenCount  output  TAKEN_W  taken-branch counter

Behaviour:
- Reset (sync, priority over everything, also mid-instruction): PC=RESET_PC, Instr=0 (so Opcode=0 holds the FSM in fetch), ALUOut=0, BranchTaken=0, InstrCount=0, TakenCount=0.
- ALUOut <= ALUResult every non-reset cycle; one-cycle latency. It carries the branch target computed in the decode state into the branch state.
- Jump target = {PC[ADDR_W-1:26], Instr[25:0]}. Uses the current PC, i.e. already incremented at fetch.
- cond = (Branch==01 & Zero) | (Branch==10 & ~Zero); Branch==11 never taken.
- pc_en = PCWrite | cond.
- When pc_en: PC <= mux(PCSrc). PCSrc==11 with pc_en: PC holds. Otherwise PC holds.
- PCWrite and cond both true: single update, PCSrc selects; the branch is counted as taken only if cond.
- IRWrite: Instr <= MemData on the same edge PC updates. Fetch reads MemData at the pre-update PC.
- IRWrite=1 with PCWrite=0 (FSM idle/default state): IR loads, PC holds, InstrCount not incremented.
- InstrCount increments when IRWrite & PCWrite; wraps 0xFFFFFFFF -> 0.
- TakenCount increments when cond; wraps at 2^TAKEN_W.
- BranchTaken <= cond; high exactly one cycle after the resolving edge.
- Opcode is purely combinational from Instr: no added latency.
- No X propagation: all outputs defined from the first post-reset cycle.

Decomposition:
- Shared package (cpu_pkg): PCSrc encodings (PCSRC_ALU=00, PCSRC_ALUOUT=01, PCSRC_JUMP=10), Branch encodings (BR_NONE=00, BR_EQ=01, BR_NE=10), OPCODE_MSB/LSB=31/26, JUMP_FIELD_W=26.
- One natural sub-module: branch_resolve (Branch, Zero -> cond), kept combinational. Registers stay in pc_fetch_unit.

Test Plan:
- Reset then fetch: Reset 1 cycle; MemData=0x0C000005, ALUResult=1, PCWrite=IRWrite=1, PCSrc=00 -> PC=1, Opcode=0x03, InstrCount=1.
- BEQ taken: ALUResult=0x40 on cycle N (ALUOut=0x40 at N+1); on N+1 Branch=01, PCSrc=01, Zero=1 -> PC=0x40, BranchTaken=1 at N+2, TakenCount=1.
- BNE not taken: same setup, Branch=10, Zero=1 -> PC unchanged, BranchTaken=0, TakenCount unchanged.
- Jump: PC=0x10000004, Instr=0x0800ABCD, PCWrite=1, PCSrc=10 -> PC=0x1000ABCD; InstrCount unchanged because IRWrite=0.
- Reserved codes: PCSrc=11 with PCWrite=1 -> PC holds. Branch=11, Zero=1 -> no update, TakenCount unchanged.
- Reset mid-instruction after PC=0x40: Reset=1 -> next cycle PC=0, Instr=0, Opcode=0, counters=0. Counter wrap: preload InstrCount=0xFFFFFFFF, fetch -> 0.
